exposure_timer: RTL and testbench
=================================

Name: exposure_timer

Overview:
Programmable exposure-time counter for the camera controller. It holds the user-set exposure time (ms) and times the EXPOSE phase. A Start pulse from the exposure-control FSM launches the count, and Ovf5 is returned to the FSM when the time has elapsed. It sits directly upstream of the exposure-control FSM, which consumes Ovf5.

Parameters:
CLK_PER_MS, 1000, Clk cycles per exposure time unit (1 ms); must be >= 2.
EXP_MIN, 2, minimum exposure time in ms.
EXP_MAX, 30, maximum exposure time in ms; must be <= 31.
EXP_DEFAULT, 2, exposure time loaded at reset; EXP_MIN <= EXP_DEFAULT <= EXP_MAX.

Ports:
Clk  input  1  system clock; all logic on rising edge.
Reset  input  1  synchronous, active-low reset.
Exp_increase  input  1  level from the button (already synchronised); each rising edge adds 1 ms.
Exp_decrease  input  1  level from the button (already synchronised); each rising edge subtracts 1 ms.
Start  input  1  one-cycle pulse from the FSM that starts the exposure count.
Ovf5  output  1  one-cycle pulse when the exposure time has elapsed.
Busy  output  1  high while an exposure count is running.
Exp_time  output  5  current exposure setting in ms.

Behaviour:
- Interface: one clock (Clk). Reset is synchronous and active-low: sampled only on the Clk rising edge, and it clears state when low.
- Reset values:
  - Exp_time = EXP_DEFAULT.
  - Ovf5 = 0, Busy = 0, state = IDLE.
  - Prescaler = 0, ms counter = 0.
  - Button edge registers = 0.
- Reset mid-count: the count aborts at once and no Ovf5 is issued.
- Button edge detection: keep a registered copy of each button level. A rising edge is detected when the current level is 1 and the registered copy is 0.
- Exposure register updates:
  - Updated only in IDLE.
  - Increase edge only: Exp_time+1, saturating at EXP_MAX.
  - Decrease edge only: Exp_time-1, saturating at EXP_MIN.
  - Both edges in the same cycle: no change.
  - Edges detected while Busy are discarded; they are not queued.
  - The update is visible on Exp_time the cycle after the edge.
- State machine, IDLE -> RUN:
  - Transition occurs on the edge where Start=1 is sampled in IDLE.
  - On that edge: ms counter <= Exp_time, prescaler <= 0, Busy <= 1.
- State machine, in RUN:
  - The prescaler counts 0..CLK_PER_MS-1 and wraps.
  - On each wrap the ms counter decrements by 1.
  - The wrap that takes the ms counter from 1 to 0 asserts Ovf5 for exactly that cycle. On the next edge the block returns to IDLE with Busy=0.
- Latency:
  - Busy is high for exactly Exp_time*CLK_PER_MS cycles, starting the cycle after Start is sampled.
  - Ovf5 is high in the last of these cycles only.
- Start while Busy, including the Ovf5 cycle: ignored.
- Start and a button edge in the same IDLE cycle: Start wins, the count uses the pre-update Exp_time, and the button edge is discarded.
- Exp_time latching: Exp_time is captured at Start, so the running count is never affected by it changing later. Exp_time is held constant during RUN anyway.
- Widths and wrap-around:
  - The ms counter is 5 bits.
  - The prescaler is clog2(CLK_PER_MS) bits.
  - Neither counter wraps below 0; the block leaves RUN at 0.
- Ovf5 is never asserted in IDLE and never for more than 1 cycle.

Test Plan:
1. Reset low for 2 cycles, then high -> Exp_time=2, Busy=0, Ovf5=0. With CLK_PER_MS=4, Start pulse -> Busy high for 8 cycles, Ovf5 high only in the 8th, Busy low in the 9th.
2. 30 increase edges from EXP_DEFAULT=2 -> Exp_time saturates at 30. Start -> Ovf5 exactly 120 cycles after Start is sampled (CLK_PER_MS=4). Then 40 decrease edges -> Exp_time=2, no underflow.
3. Exp_increase and Exp_decrease rising in the same cycle with Exp_time=5 -> Exp_time stays 5. Holding Exp_increase high for 10 cycles -> only +1 (Exp_time=6).
4. Start with Exp_time=3, then Start and increase edges during RUN, including in the Ovf5 cycle -> exactly one Ovf5 at cycle 12, Exp_time still 3, and no second count starts.
5. Start with Exp_time=10, then Reset low at cycle 15 -> the next edge gives Busy=0 and Exp_time=2, and no Ovf5 appears over the following 50 cycles.
6. Start and an increase edge in the same cycle with Exp_time=4 -> Ovf5 after 16 cycles and Exp_time remains 4.

Source files
------------

// File: rtl/exposure_timer.sv
// -----------------------------------------------------------------------------
// exposure_timer
//
// Holds the user-set exposure time (in ms) and times the EXPOSE phase for the
// exposure-control FSM. A one-cycle Start pulse in IDLE captures Exp_time into
// a millisecond down-counter. A prescaler divides Clk down to 1 ms ticks. Ovf5
// pulses in the last busy cycle, and the block then returns to IDLE.
//
// Ports:
//   Clk           system clock, rising edge
//   Reset         synchronous, active-low reset
//   Exp_increase  synchronised button level; each rising edge adds 1 ms (IDLE)
//   Exp_decrease  synchronised button level; each rising edge subtracts 1 ms
//   Start         one-cycle pulse that launches an exposure count
//   Ovf5          one-cycle pulse in the final cycle of the count
//   Busy          high while a count is running
//   Exp_time      current exposure setting in ms
// -----------------------------------------------------------------------------
module exposure_timer #(
  parameter int CLK_PER_MS  = 1000,
  parameter int EXP_MIN     = 2,
  parameter int EXP_MAX     = 30,
  parameter int EXP_DEFAULT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Exp_increase,
  input  logic       Exp_decrease,
  input  logic       Start,
  output logic       Ovf5,
  output logic       Busy,
  output logic [4:0] Exp_time
);

  localparam int PW = $clog2(CLK_PER_MS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);
  localparam logic [4:0]    EXP_MIN_V  = 5'(EXP_MIN);
  localparam logic [4:0]    EXP_MAX_V  = 5'(EXP_MAX);
  localparam logic [4:0]    EXP_DEF_V  = 5'(EXP_DEFAULT);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [PW-1:0] presc, presc_next;
  logic [4:0]    ms_cnt, ms_next;
  logic [4:0]    exp_next;
  logic          inc_q, dec_q;
  logic          inc_edge, dec_edge;

  assign inc_edge = Exp_increase & ~inc_q;
  assign dec_edge = Exp_decrease & ~dec_q;

  // NOTE: every combinational output gets a default before any branch, so no
  // path can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    presc_next = presc;
    ms_next    = ms_cnt;
    exp_next   = Exp_time;
    Ovf5       = 1'b0;
    Busy       = (state == RUN);

    unique case (state)
      IDLE: begin
        // Start has priority: the count uses the current setting and any
        // simultaneous button edge is dropped.
        if (Start) begin
          state_next = RUN;
          ms_next    = Exp_time;
          presc_next = '0;
        end else if (inc_edge && !dec_edge) begin
          if (Exp_time < EXP_MAX_V) exp_next = Exp_time + 5'd1;
        end else if (dec_edge && !inc_edge) begin
          if (Exp_time > EXP_MIN_V) exp_next = Exp_time - 5'd1;
        end
      end

      RUN: begin
        if (presc == PRESC_LAST) begin
          presc_next = '0;
          ms_next    = ms_cnt - 5'd1;
          // Last millisecond wrap: flag the elapsed time in this very cycle.
          // The <= also guarantees an exit should the counter ever read 0.
          if (ms_cnt <= 5'd1) begin
            Ovf5       = 1'b1;
            ms_next    = '0;
            state_next = IDLE;
          end
        end else begin
          presc_next = presc + 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= IDLE;
      presc    <= '0;
      ms_cnt   <= '0;
      Exp_time <= EXP_DEF_V;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
    end else begin
      state    <= state_next;
      presc    <= presc_next;
      ms_cnt   <= ms_next;
      Exp_time <= exp_next;
      // Button copies track the level continuously. Edges seen while busy
      // are thereby consumed and never replayed.
      inc_q    <= Exp_increase;
      dec_q    <= Exp_decrease;
    end
  end

endmodule

// File: tb/tb_exposure_timer.sv
// -----------------------------------------------------------------------------
// tb_exposure_timer
//
// Directed testbench for exposure_timer with CLK_PER_MS = 4. Inputs change and
// outputs are sampled 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_exposure_timer;

  localparam int CPM = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inc;
  logic       dec;
  logic       start;
  logic       ovf5;
  logic       busy;
  logic [4:0] exp_time;

  int n_cmp = 0;
  int n_bad = 0;

  exposure_timer #(
    .CLK_PER_MS (CPM),
    .EXP_MIN    (2),
    .EXP_MAX    (30),
    .EXP_DEFAULT(2)
  ) dut (
    .Clk         (clk),
    .Reset       (rst_n),
    .Exp_increase(inc),
    .Exp_decrease(dec),
    .Start       (start),
    .Ovf5        (ovf5),
    .Busy        (busy),
    .Exp_time    (exp_time)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_inc(input int n);
    for (int k = 0; k < n; k++) begin
      inc = 1'b1; tick();
      inc = 1'b0; tick();
    end
  endtask

  task automatic pulse_dec(input int n);
    for (int k = 0; k < n; k++) begin
      dec = 1'b1; tick();
      dec = 1'b0; tick();
    end
  endtask

  // Pulses Start (with an optional increase edge in the same cycle), then
  // observes `window` cycles. With poke set, Start is held high and Exp_increase
  // toggles through busy cycles 1..n_exp. Both are released in cycle n_exp+1.
  task automatic run_and_measure(input int n_exp, input int window,
                                 input bit poke, input bit inc_with_start,
                                 output int busy_cnt, output int ovf_cnt,
                                 output int ovf_at, output bit first_busy,
                                 output bit busy_after);
    busy_cnt = 0; ovf_cnt = 0; ovf_at = -1; first_busy = 1'b0; busy_after = 1'b1;
    start = 1'b1;
    if (inc_with_start) inc = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= window; i++) begin
      if (busy) busy_cnt++;
      if (ovf5) begin
        ovf_cnt++;
        if (ovf_at < 0) ovf_at = i;
      end
      if (i == 1)         first_busy = busy;
      if (i == n_exp + 1) busy_after = busy;
      if (poke) begin
        start = (i <= n_exp);
        inc   = (i <= n_exp) && (i % 2 == 0);
      end
      tick();
    end
    start = 1'b0;
    inc   = 1'b0;
    tick();
  endtask

  task automatic check_count(input string name, input int n_exp,
                             input int busy_cnt, input int ovf_cnt,
                             input int ovf_at, input bit first_busy,
                             input bit busy_after);
    n_cmp++;
    if (first_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s busy_first: got %0b want 1", name, first_busy);
    end
    n_cmp++;
    if (busy_cnt != n_exp) begin
      n_bad++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, n_exp);
    end
    n_cmp++;
    if (ovf_cnt != 1) begin
      n_bad++;
      $display("FAIL %s ovf_count: got %0d want 1", name, ovf_cnt);
    end
    n_cmp++;
    if (ovf_at != n_exp) begin
      n_bad++;
      $display("FAIL %s ovf_cycle: got %0d want %0d", name, ovf_at, n_exp);
    end
    n_cmp++;
    if (busy_after !== 1'b0) begin
      n_bad++;
      $display("FAIL %s busy_after: got %0b want 0", name, busy_after);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; inc = 1'b0; dec = 1'b0; start = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    n_cmp++;
    if (exp_time !== 5'd2) begin
      n_bad++; $display("FAIL reset_exp: got %0d want 2", exp_time);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_busy: got %0b want 0", busy);
    end
    n_cmp++;
    if (ovf5 !== 1'b0) begin
      n_bad++; $display("FAIL reset_ovf5: got %0b want 0", ovf5);
    end
  endtask

  task automatic test_basic_count();
    int bc, oc, oa; bit fb, ba;
    run_and_measure(8, 14, 1'b0, 1'b0, bc, oc, oa, fb, ba);
    check_count("basic", 8, bc, oc, oa, fb, ba);
  endtask

  task automatic test_saturation();
    int bc, oc, oa; bit fb, ba;
    pulse_inc(30);
    n_cmp++;
    if (exp_time !== 5'd30) begin
      n_bad++; $display("FAIL sat_max: got %0d want 30", exp_time);
    end
    run_and_measure(120, 130, 1'b0, 1'b0, bc, oc, oa, fb, ba);
    check_count("max_count", 120, bc, oc, oa, fb, ba);
    pulse_dec(1);
    n_cmp++;
    if (exp_time !== 5'd29) begin
      n_bad++; $display("FAIL dec_one: got %0d want 29", exp_time);
    end
    pulse_dec(39);
    n_cmp++;
    if (exp_time !== 5'd2) begin
      n_bad++; $display("FAIL sat_min: got %0d want 2", exp_time);
    end
  endtask

  task automatic test_buttons();
    pulse_inc(3);
    inc = 1'b1; dec = 1'b1;
    tick();
    n_cmp++;
    if (exp_time !== 5'd5) begin
      n_bad++; $display("FAIL both_edges: got %0d want 5", exp_time);
    end
    inc = 1'b0; dec = 1'b0;
    tick();
    inc = 1'b1;
    tick();
    n_cmp++;
    if (exp_time !== 5'd6) begin
      n_bad++; $display("FAIL next_cycle_update: got %0d want 6", exp_time);
    end
    for (int k = 0; k < 9; k++) tick();
    n_cmp++;
    if (exp_time !== 5'd6) begin
      n_bad++; $display("FAIL held_level: got %0d want 6", exp_time);
    end
    inc = 1'b0;
    tick();
  endtask

  task automatic test_busy_ignore();
    int bc, oc, oa; bit fb, ba;
    pulse_dec(3);
    n_cmp++;
    if (exp_time !== 5'd3) begin
      n_bad++; $display("FAIL setup_3: got %0d want 3", exp_time);
    end
    run_and_measure(12, 30, 1'b1, 1'b0, bc, oc, oa, fb, ba);
    check_count("busy_ignore", 12, bc, oc, oa, fb, ba);
    n_cmp++;
    if (exp_time !== 5'd3) begin
      n_bad++; $display("FAIL busy_exp: got %0d want 3", exp_time);
    end
  endtask

  task automatic test_reset_mid_count();
    int ovf_seen = 0;
    int busy_seen = 0;
    pulse_inc(7);
    n_cmp++;
    if (exp_time !== 5'd10) begin
      n_bad++; $display("FAIL setup_10: got %0d want 10", exp_time);
    end
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      if (ovf5) ovf_seen++;
      tick();
    end
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL abort_busy: got %0b want 0", busy);
    end
    n_cmp++;
    if (exp_time !== 5'd2) begin
      n_bad++; $display("FAIL abort_exp: got %0d want 2", exp_time);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (ovf5) ovf_seen++;
      if (busy) busy_seen++;
      tick();
    end
    n_cmp++;
    if (ovf_seen != 0) begin
      n_bad++; $display("FAIL abort_ovf5: got %0d pulses want 0", ovf_seen);
    end
    n_cmp++;
    if (busy_seen != 0) begin
      n_bad++; $display("FAIL abort_restart: got %0d busy cycles want 0", busy_seen);
    end
  endtask

  task automatic test_start_with_edge();
    int bc, oc, oa; bit fb, ba;
    pulse_inc(2);
    n_cmp++;
    if (exp_time !== 5'd4) begin
      n_bad++; $display("FAIL setup_4: got %0d want 4", exp_time);
    end
    run_and_measure(16, 22, 1'b0, 1'b1, bc, oc, oa, fb, ba);
    check_count("start_edge", 16, bc, oc, oa, fb, ba);
    n_cmp++;
    if (exp_time !== 5'd4) begin
      n_bad++; $display("FAIL start_edge_exp: got %0d want 4", exp_time);
    end
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_saturation();
    test_buttons();
    test_busy_ignore();
    test_reset_mid_count();
    test_start_with_edge();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
